// File: rtl/minmax_window_reader_pkg.sv
// Shared definitions for the min/max tracker family: pipeline latency,
// reader FSM states and the result sequence-number width.
package minmax_pkg;

  localparam int unsigned seq_w = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Depth of the tracker reduction tree; a single lane has no tree stage.
  function automatic int unsigned minmax_latency(input int unsigned n);
    if (n <= 32'd1) begin
      return 32'd0;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/minmax_window_reader_if.sv
// Result port of the window reader: one captured min/max pair per window,
// transferred with valid/ready.
interface minmax_window_reader_if #(
  parameter int unsigned dw = 16
);
  import minmax_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [dw-1:0]     out_min;
  logic [dw-1:0]     out_max;
  logic [seq_w-1:0]  out_seq;

  modport master (
    output out_valid, out_min, out_max, out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_min, out_max, out_seq,
    output out_ready
  );
endinterface

// File: rtl/minmax_strobe_delay.sv
// D-stage single-bit delay line with synchronous clear; a plain wire when d = 0.
module minmax_strobe_delay #(
  parameter int unsigned d = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  if (d == 0) begin : g_wire
    assign dout = din;
  end else begin : g_shift
    logic [d-1:0] sr_r;

    // Shift register; several strobes may be in flight when windows are short.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sr_r <= '0;
      end else if (clr) begin
        sr_r <= '0;
      end else begin
        sr_r[0] <= din;
        for (int i = 1; i < int'(d); i++) begin
          sr_r[i] <= sr_r[i-1];
        end
      end
    end

    assign dout = sr_r[d-1];
  end

endmodule

// File: rtl/minmax_window_reader.sv
// Window controller and result reader for the parallel min/max tracker:
// pulses tracker_reset once per window and captures the result D cycles later.
module minmax_window_reader
  import minmax_pkg::*;
#(
  parameter int unsigned dw = 16,
  parameter int unsigned n  = 4,
  parameter int unsigned cw = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [cw-1:0]         window_len,
  input  logic signed [dw-1:0]  xmin,
  input  logic signed [dw-1:0]  xmax,
  output logic                  tracker_reset,
  output logic                  overrun,
  minmax_window_reader_if.master rd
);

  localparam int unsigned d = minmax_latency(n);

  state_t           state_r;
  state_t           next_s;
  logic [cw-1:0]    cnt_r;
  logic [cw-1:0]    w_s;
  logic             tr_r;
  logic             run_s;
  logic             entry_s;
  logic             strobe_s;
  logic             capture_s;
  logic             xfer_s;
  logic             first_r;
  logic             valid_r;
  logic             overrun_r;
  logic [dw-1:0]    min_r;
  logic [dw-1:0]    max_r;
  logic [seq_w-1:0] seq_r;

  assign w_s       = (window_len == {cw{1'b0}}) ? cw'(1) : window_len;
  assign run_s     = (state_r == RUN) && enable;
  assign entry_s   = (state_r == IDLE) && enable;
  assign xfer_s    = valid_r && rd.out_ready;

  minmax_strobe_delay #(.d(d)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run_s),
    .din     (run_s && tr_r),
    .dout    (strobe_s)
  );

  // Dropping enable discards any strobe emerging on that same edge.
  assign capture_s = strobe_s && run_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) next_s = RUN;
        else        next_s = IDLE;
      end
      RUN: begin
        if (!enable) next_s = IDLE;
        else         next_s = RUN;
      end
      default: next_s = IDLE;
    endcase
  end

  // Window down-counter; tr_r is high in the last cycle of each window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
      tr_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            cnt_r <= w_s;
            tr_r  <= (w_s == cw'(1));
          end else begin
            cnt_r <= '0;
            tr_r  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            cnt_r <= '0;
            tr_r  <= 1'b1;
          end else if (cnt_r <= cw'(1)) begin
            cnt_r <= w_s;
            tr_r  <= (w_s == cw'(1));
          end else begin
            cnt_r <= cnt_r - cw'(1);
            tr_r  <= (cnt_r == cw'(2));
          end
        end
        default: begin
          cnt_r <= '0;
          tr_r  <= 1'b1;
        end
      endcase
    end
  end

  // Result register, handshake and sequence numbering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      first_r   <= 1'b1;
      min_r     <= '0;
      max_r     <= '0;
      seq_r     <= '0;
    end else if (capture_s) begin
      valid_r <= 1'b1;
      min_r   <= xmin;
      max_r   <= xmax;
      first_r <= 1'b0;
      if (!first_r) seq_r <= seq_r + seq_w'(1);
      if (valid_r && !rd.out_ready) overrun_r <= 1'b1;
    end else begin
      if (xfer_s) valid_r <= 1'b0;
      if (entry_s) begin
        seq_r     <= '0;
        overrun_r <= 1'b0;
        first_r   <= 1'b1;
      end
    end
  end

  assign tracker_reset = tr_r;
  assign overrun       = overrun_r;
  assign rd.out_valid  = valid_r;
  assign rd.out_min    = min_r;
  assign rd.out_max    = max_r;
  assign rd.out_seq    = seq_r;

endmodule

// File: tb/tb_minmax_window_reader.sv
// Directed bench for minmax_window_reader; xmax follows a cycle counter and
// xmin its negation, so each captured value identifies its capture edge.
module tb_minmax_window_reader;
  import minmax_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] window_len;
  logic [15:0] xmin_s;
  logic [15:0] xmax_s;
  logic        tracker_reset;
  logic        overrun;
  int          cyc;
  int          ce;
  int          n_assert;
  int          n_fail;

  minmax_window_reader_if #(.dw(16)) rd ();

  minmax_window_reader #(.dw(16), .n(4), .cw(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .window_len    (window_len),
    .xmin          (xmin_s),
    .xmax          (xmax_s),
    .tracker_reset (tracker_reset),
    .overrun       (overrun),
    .rd            (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  assign xmax_s = cyc[15:0];
  assign xmin_s = 16'(32'sd0 - cyc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e16(input int v);
    logic [31:0] t;
    t = v;
    return {16'h0000, t[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle E+1 is the cycle after the enable edge E.
  task automatic go_to(input int k);
    int guard;
    guard = 0;
    while ((cyc - ce + 1) < k && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) chk("go_to_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_run(input logic [15:0] w);
    window_len = w;
    enable = 1'b1;
    step();
    ce = cyc;
  endtask

  task automatic chk_result(input string tag, input int cap, input int seq);
    chk({tag, "_valid"}, {31'd0, rd.out_valid}, 32'd1);
    chk({tag, "_max"}, {16'h0000, rd.out_max}, e16(cap));
    chk({tag, "_min"}, {16'h0000, rd.out_min}, e16(0 - cap));
    chk({tag, "_seq"}, {16'h0000, rd.out_seq}, e16(seq));
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    cyc          = 0;
    ce           = 0;
    reset_n      = 1'b0;
    enable       = 1'b0;
    window_len   = 16'd8;
    rd.out_ready = 1'b1;

    // Reset values.
    #12;
    chk("rst_tr", {31'd0, tracker_reset}, 32'd1);
    chk("rst_valid", {31'd0, rd.out_valid}, 32'd0);
    chk("rst_min", {16'h0000, rd.out_min}, 32'd0);
    chk("rst_max", {16'h0000, rd.out_max}, 32'd0);
    chk("rst_seq", {16'h0000, rd.out_seq}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_tr", {31'd0, tracker_reset}, 32'd1);
    chk("idle_valid", {31'd0, rd.out_valid}, 32'd0);

    // Contiguous 8-sample windows with out_ready held high.
    start_run(16'd8);
    for (int k = 1; k <= 28; k++) begin
      chk("w8_tr", {31'd0, tracker_reset}, {31'd0, (k % 8) == 0});
      if (k >= 11 && ((k - 11) % 8) == 0) begin
        chk_result("w8", ce + k - 2, (k - 11) / 8);
      end else begin
        chk("w8_idle_valid", {31'd0, rd.out_valid}, 32'd0);
      end
      step();
    end
    chk("w8_ovr", {31'd0, overrun}, 32'd0);
    enable = 1'b0;
    step();

    // Backpressure: second capture overwrites the first.
    rd.out_ready = 1'b0;
    start_run(16'd8);
    go_to(11);
    chk_result("bp0", ce + 9, 0);
    chk("bp0_ovr", {31'd0, overrun}, 32'd0);
    go_to(19);
    chk_result("bp1", ce + 17, 1);
    chk("bp1_ovr", {31'd0, overrun}, 32'd1);
    go_to(20);
    rd.out_ready = 1'b1;
    step();
    chk("bp_acc_valid", {31'd0, rd.out_valid}, 32'd0);
    go_to(27);
    chk_result("bp2", ce + 25, 2);
    chk("bp2_ovr", {31'd0, overrun}, 32'd1);
    enable = 1'b0;
    step();
    chk("bp_off_tr", {31'd0, tracker_reset}, 32'd1);

    // Accept and capture on the same edge.
    rd.out_ready = 1'b0;
    start_run(16'd8);
    chk("same_entry_ovr", {31'd0, overrun}, 32'd0);
    go_to(18);
    chk_result("same0", ce + 9, 0);
    rd.out_ready = 1'b1;
    step();
    chk_result("same1", ce + 17, 1);
    chk("same_ovr", {31'd0, overrun}, 32'd0);
    enable = 1'b0;
    step();
    step();

    // Window length 1, then switch to 0 while running.
    start_run(16'd1);
    for (int k = 1; k <= 14; k++) begin
      if (k == 8) window_len = 16'd0;
      chk("w1_tr", {31'd0, tracker_reset}, 32'd1);
      if (k >= 4) chk_result("w1", ce + k - 2, k - 4);
      else        chk("w1_pre_valid", {31'd0, rd.out_valid}, 32'd0);
      step();
    end
    enable = 1'b0;
    step();
    step();
    chk("w0_gap_valid", {31'd0, rd.out_valid}, 32'd0);

    // Window length 0 from a fresh start.
    start_run(16'd0);
    chk("w0_tr", {31'd0, tracker_reset}, 32'd1);
    go_to(3);
    chk("w0_pre_valid", {31'd0, rd.out_valid}, 32'd0);
    go_to(4);
    chk_result("w0a", ce + 2, 0);
    step();
    chk_result("w0b", ce + 3, 1);
    chk("w0_tr2", {31'd0, tracker_reset}, 32'd1);
    enable = 1'b0;
    step();
    step();

    // Mid-window disable with a result pending.
    rd.out_ready = 1'b0;
    start_run(16'd8);
    go_to(12);
    chk_result("mid_pend", ce + 9, 0);
    enable = 1'b0;
    step();
    chk("mid_tr", {31'd0, tracker_reset}, 32'd1);
    go_to(25);
    chk_result("mid_held", ce + 9, 0);
    chk("mid_tr2", {31'd0, tracker_reset}, 32'd1);
    rd.out_ready = 1'b1;
    step();
    chk("mid_acc_valid", {31'd0, rd.out_valid}, 32'd0);
    rd.out_ready = 1'b0;
    start_run(16'd8);
    go_to(10);
    chk("re_pre_valid", {31'd0, rd.out_valid}, 32'd0);
    go_to(13);
    chk_result("re_seq0", ce + 9, 0);
    chk("re_ovr", {31'd0, overrun}, 32'd0);

    // Asynchronous reset in the middle of a window.
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk("arst_tr", {31'd0, tracker_reset}, 32'd1);
    chk("arst_valid", {31'd0, rd.out_valid}, 32'd0);
    chk("arst_min", {16'h0000, rd.out_min}, 32'd0);
    chk("arst_max", {16'h0000, rd.out_max}, 32'd0);
    chk("arst_seq", {16'h0000, rd.out_seq}, 32'd0);
    chk("arst_ovr", {31'd0, overrun}, 32'd0);
    step();
    reset_n = 1'b1;
    rd.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("post_tr", {31'd0, tracker_reset}, 32'd1);
      chk("post_valid", {31'd0, rd.out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_window_reader.md
# minmax_window_reader

Window controller and result reader for the parallel min/max tracker. It divides the sample stream into contiguous windows of programmable length and drives the tracker's reset input to start each window. It captures the tracker's min/max at the pipeline-correct cycle and presents each window's result downstream with a valid/ready handshake and a sequence number. It sits between the tracker and the register/readout fabric.

## Interface
- dw, 16: sample width, signed; must match the tracker.
- n, 4: tracker lanes; sets tree latency D = clog2(n) (D = 0 for n = 1).
- cw, 16: window-length counter width.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run windows while high.
- window_len  in  cw  samples per window; sampled at each window start; 0 treated as 1.
- xmin  in  dw  tracker running minimum, signed.
- xmax  in  dw  tracker running maximum, signed.
- tracker_reset  out  1  drives the tracker reset; high restarts the tracker window.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_min  out  dw  captured window minimum.
- out_max  out  dw  captured window maximum.
- out_seq  out  16  window sequence number; wraps 0xFFFF to 0.
- overrun  out  1  sticky: a result was overwritten before it was accepted.

## Operation
- **States.** IDLE and RUN.
- **IDLE.** tracker_reset held high, so the tracker continuously reloads. Window counter and strobe delay line are cleared. Transition to RUN on the edge where enable = 1. On that edge, out_seq is cleared to 0 and overrun is cleared.
- **RUN.**
  - Down-counter loaded with W = max(window_len, 1) at each window start.
  - tracker_reset is low for W−1 cycles, then high for exactly 1 cycle (the last cycle of the window). For W = 1 it is high every cycle.
  - Reload happens on that last cycle. Windows are contiguous, and each covers exactly W samples, because the tracker's reset cycle loads the new window's first sample.
- **Capture.** Each tracker_reset pulse in RUN launches a capture strobe into a D-stage delay line. The strobe emerges at the edge ending cycle T+D, where T is the pulse cycle. At that edge, out_min/out_max latch xmin/xmax, and out_valid is set.
  - Out_seq increments by 1 on each capture except the first after entering RUN, which presents seq 0.
  - The delay line handles overlapping strobes when W ≤ D.
- **Handshake.** A transfer occurs on an edge with out_valid & out_ready.
  - out_valid clears after a transfer, unless a capture happens on the same edge. In that case out_valid stays 1 with the new data, and no overrun is flagged.
  - If a capture occurs while out_valid = 1 and out_ready = 0, the new result overwrites the old one and overrun is set. out_seq still advances, so downstream can detect the gap.
- **enable low in RUN.** Go to IDLE on that edge. The partial window and in-flight strobes are discarded. A pending out_valid result is retained until accepted.
- **Arithmetic.** Comparisons stay in the tracker. This block only copies dw-bit values; there is no width growth.

## Timing
- Reset values while reset_n is low: state = IDLE, tracker_reset = 1, out_valid = 0, out_min = 0, out_max = 0, out_seq = 0, overrun = 0.
- Enable start: for enable sampled at edge E, tracker_reset is low from the cycle after E. The first pulse occurs in cycle E+W.
- Latency: out_valid rises in cycle T+D+1. That is W+D+1 cycles after E for the first window, and every W cycles thereafter.
- Throughput: one result per W cycles. Sustained operation with no overrun needs out_ready within W cycles of out_valid.
- window_len change: takes effect at the next window start, never mid-window.

## Structure
- Shared package minmax_pkg:
  - latency function minmax_latency(n) = clog2(n), also used by the tracker bench;
  - state enum {IDLE, RUN};
  - the out_seq width constant (16).
- Sub-module minmax_strobe_delay: parameterized D-stage 1-bit shift register with synchronous clear. It must degenerate to a wire for D = 0.
- FSM, window counter and output register stay in the top module.

## Test plan
Each scenario instantiates the tracker (dw = 16, n = 4, D = 2) fed by a lane-indexed ramp, with this block controlling it.
- **Window results.** window_len = 8, enable high at edge E, out_ready = 1. tracker_reset pulses in cycles E+8, E+16, … out_valid is high in cycles E+11, E+19, … with out_min/out_max equal to the reference min/max of exactly the 8×4 samples of each window. out_seq reads 0, 1, 2.
- **Backpressure.** out_ready = 0 for 20 cycles with window_len = 8. The second capture overwrites the first and overrun = 1, and out_seq skips from 0 to 1 unseen. After out_ready = 1, seq 2 follows; overrun stays 1 until re-enable.
- **Accept and capture on the same edge.** Align out_ready with the capture edge. out_valid stays high, the new data and seq are presented, and overrun = 0.
- **Short windows.** window_len = 1, then window_len = 0. tracker_reset is high every cycle and one result per cycle appears with D+1 latency. The 0 case behaves identically to 1.
- **Mid-window disable.** Drop enable 3 cycles into a window with a valid result pending. The FSM returns to IDLE with tracker_reset = 1. No further captures occur, the pending result remains until accepted, and re-enable restarts out_seq at 0.
- **Reset during RUN.** Assert reset_n = 0 mid-window with out_valid = 1. All outputs go immediately to their reset values. After release, there is no activity until enable is sampled high.
